// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared constants for the ALU and its result stage: opcode encodings,
//   bit positions inside the packed {Z,N,C,V} flag nibble, bit positions of
//   the sticky status vector, the skid-buffer occupancy encoding, and a
//   helper that decodes which sticky bits an accepted result should set.
package alu_pkg;

  // Opcode encodings shared with the ALU.
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1010;
  localparam logic [3:0] OP_SHR  = 4'b1011;
  localparam logic [3:0] OP_ROL  = 4'b1100;
  localparam logic [3:0] OP_ROR  = 4'b1101;
  localparam logic [3:0] OP_ASR  = 4'b1110;

  // Bit positions inside the flag nibble {Z,N,C,V}.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Bit positions inside the sticky vector {div_err, ovf, carry}.
  localparam int STK_DIV   = 2;
  localparam int STK_OVF   = 1;
  localparam int STK_CARRY = 0;

  // Occupancy of the two-entry skid buffer, encoded as {out_valid, skid_valid}.
  // The encoding 2'b01 (skid full, main empty) is unreachable.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

  // Sticky bits that an accepted result raises. V means "divide error" when it
  // comes from a divide and "arithmetic overflow" for every other opcode.
  function automatic logic [2:0] sticky_set(input logic [3:0] flags,
                                            input logic [3:0] opcode);
    logic [2:0] set;
    set            = '0;
    set[STK_CARRY] = flags[FLAG_C];
    set[STK_OVF]   = flags[FLAG_V] && (opcode != OP_DIV);
    set[STK_DIV]   = flags[FLAG_V] && (opcode == OP_DIV);
    return set;
  endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// alu_skid_buffer
//   Two-entry valid/ready skid buffer. The main register drives the output;
//   the skid register catches one transaction that arrives while main is
//   stalled. in_ready comes from a register, so out_ready never reaches the
//   upstream side combinationally.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake
//   in_data           upstream payload
//   out_valid/out_ready downstream handshake
//   out_data          payload held in the main register
module alu_skid_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state;
  logic             ready_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             issue;

  assign in_ready  = ready_q && !rst;
  assign out_valid = (state != SKID_EMPTY);
  assign out_data  = main_q;

  assign accept = in_valid && ready_q;
  assign issue  = out_valid && out_ready;

  // ready_q tracks "skid will be empty next cycle", so it falls in the same
  // edge that fills skid and rises in the same edge that drains it.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SKID_EMPTY;
      ready_q <= 1'b0;
      main_q  <= '0;
    end else begin
      case (state)
        SKID_EMPTY: begin
          ready_q <= 1'b1;
          if (accept) begin
            main_q <= in_data;
            state  <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          ready_q <= !(accept && !issue);
          case ({accept, issue})
            2'b01: state <= SKID_EMPTY;
            2'b10: begin
              skid_q <= in_data;
              state  <= SKID_FULL;
            end
            2'b11: main_q <= in_data;
            default: ;
          endcase
        end
        SKID_FULL: begin
          // No accept is possible here: ready_q was low for the whole cycle.
          ready_q <= issue;
          if (issue) begin
            main_q <= skid_q;
            state  <= SKID_ONE;
          end
        end
        default: begin
          state   <= SKID_EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: skid_q is a pure data holder qualified by state, so it is left out of
  // reset; only contents that are visible after reset (main_q) are cleared.

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Registered output stage behind the combinational ALU. Captures result,
//   {Z,N,C,V} flags and opcode through a two-entry skid buffer, and keeps
//   sticky status bits plus a wrapping count of accepted operations.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        handshake from the ALU
//   in_result/in_flags/in_opcode  ALU outputs and the issuing opcode
//   out_valid/out_ready      handshake to register-file writeback
//   out_result/out_flags/out_opcode  registered copy of the transaction
//   clr_sticky               one-cycle pulse clearing the sticky bits
//   sticky                   {div_err, ovf, carry}
//   op_count                 number of accepted transactions, wrapping
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int NUM_BITS = 8,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_result,
  input  logic [3:0]          in_flags,
  input  logic [3:0]          in_opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_result,
  output logic [3:0]          out_flags,
  output logic [3:0]          out_opcode,
  input  logic                clr_sticky,
  output logic [2:0]          sticky,
  output logic [CNT_BITS-1:0] op_count
);

  localparam int PAYLOAD_W = NUM_BITS + 8;

  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 accept;

  assign in_payload = {in_result, in_flags, in_opcode};
  assign {out_result, out_flags, out_opcode} = out_payload;

  alu_skid_buffer #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign accept = in_valid && in_ready;

  // The clear is applied first and the accept's set bits are OR-ed on top, so
  // a set in the same cycle as a clear survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky   <= '0;
      op_count <= '0;
    end else begin
      sticky <= (clr_sticky ? 3'b000 : sticky)
              | (accept ? sticky_set(in_flags, in_opcode) : 3'b000);
      if (accept) begin
        op_count <= op_count + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the combinational `ALU`. It captures `Result`, the `Z`, `N`, `C` and `V` flags, and the issuing opcode through a valid/ready handshake. It holds them in a 2-entry skid buffer so the consumer (register-file writeback) can stall without combinational backpressure reaching the ALU. It also keeps sticky status flags and an accepted-operation counter for software readout.

## Interface
- `NUM_BITS`, 8, datapath width; must equal the ALU's `NUM_BITS`.
- `CNT_BITS`, 16, width of the operation counter.

Ports, clock and reset first:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  ALU result presented this cycle.
- `in_ready`  out  1  stage can accept; equals `!skid_valid && !rst`, driven from registers only.
- `in_result`  in  NUM_BITS  ALU `Result`.
- `in_flags`  in  4  ALU flags, packed as {Z,N,C,V} on bits [3:0].
- `in_opcode`  in  4  opcode that produced the result.
- `out_valid`  out  1  `out_*` data valid.
- `out_ready`  in  1  consumer accepts this cycle.
- `out_result`  out  NUM_BITS  registered result.
- `out_flags`  out  4  registered {Z,N,C,V}.
- `out_opcode`  out  4  registered opcode.
- `clr_sticky`  in  1  clear all sticky bits (single-cycle pulse).
- `sticky`  out  3  {div_err, ovf, carry}.
- `op_count`  out  CNT_BITS  number of accepted transactions.

## Operation
- Accept: `in_valid && in_ready`. Issue: `out_valid && out_ready`.
- Storage is a main register (drives `out_*`) plus a skid register.
- Accept while main is empty, or while main is issuing in the same cycle: data goes to main.
- Accept while main is full and not issuing: data goes to skid, and `skid_valid` is set.
- Issue while skid is full: skid moves to main, and skid is cleared. `in_ready` is 0 in this cycle, because skid was full at the start of it.
- States (`{out_valid, skid_valid}`):
  - EMPTY 00 to ONE 10 on accept.
  - ONE 10:
    - to EMPTY on issue without accept;
    - stays ONE on issue with accept;
    - to FULL 11 on accept without issue.
  - FULL 11 to ONE on issue.
  - State 01 is illegal.
- Data order is strictly FIFO. No transaction is dropped or duplicated.
- Sticky bits update on accept only:
  - `carry` is set when C=1.
  - `ovf` is set when V=1 and opcode is not 4'b0011.
  - `div_err` is set when V=1 and opcode is 4'b0011 (divide by zero or signed divide overflow).
- `clr_sticky` clears all three sticky bits. If an accept sets a bit in the same cycle, the set wins: the bit reads 1 the next cycle.
- `op_count` increments by 1 on every accept and wraps modulo 2^CNT_BITS without any flag.
- The stage never modifies data. Flags are forwarded exactly as produced by the ALU.

## Timing
- Latency: a transaction accepted in cycle t is on `out_*` with `out_valid`=1 in cycle t+1 if main was empty.
- Throughput: 1 transaction per cycle while `out_ready`=1.
- `in_ready` depends only on registered state; there is no combinational path from `out_ready`. After a stall with FULL, `in_ready` returns to 1 one cycle after the first issue.
- Reset values while `rst` is high and in the first cycle after:
  - `out_valid`=0, `in_ready`=0 (becomes 1 the cycle after `rst` falls);
  - `out_result`, `out_flags`, `out_opcode` = 0;
  - `sticky`=0, `op_count`=0.
- Reset mid-operation: both entries are discarded, and in-flight transactions are lost with no partial issue.
- `out_*` data holds stable while `out_valid && !out_ready`.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants `OP_ADD`..`OP_ASR` (4'b0000..4'b1110), including `OP_DIV`=4'b0011;
  - flag bit indices `FLAG_Z`=3, `FLAG_N`=2, `FLAG_C`=1, `FLAG_V`=0;
  - sticky indices `STK_DIV`=2, `STK_OVF`=1, `STK_CARRY`=0.
- One sub-module, `alu_skid_buffer`, parameterised by payload width (NUM_BITS+8), implements the 2-entry handshake.
- Sticky and counter logic live in `alu_result_stage` itself.

## Test plan
- Streaming with `out_ready`=1:
  - Stimulus: 5 back-to-back accepts of results 0x01..0x05.
  - Response: outputs appear in order at t+1 to t+5, `in_ready` stays 1, and `op_count`=5.
- Stall to FULL, then drain:
  - Stimulus: accept 0xA1 and 0xA2 with `out_ready`=0.
  - Response: `in_ready`=0 in the next cycle and `out_result` holds 0xA1. After `out_ready`=1, 0xA1 then 0xA2 issue on consecutive cycles and `in_ready` returns to 1.
- Division error:
  - Stimulus: accept opcode 0011 with flags 4'b1001.
  - Response: `sticky`=3'b100 the next cycle. A following ADD with V=1 makes `sticky`=3'b110.
- Clear versus set collision:
  - Stimulus: `clr_sticky`=1 in the same cycle as an accept with C=1, while `sticky`=3'b110.
  - Response: `sticky`=3'b001 the next cycle.
- Counter wrap with CNT_BITS=4:
  - Stimulus: 17 accepts.
  - Response: `op_count`=1.
- Reset while FULL:
  - Stimulus: assert `rst` for 1 cycle.
  - Response: `out_valid`=0, `op_count`=0 and `sticky`=0 the next cycle, with `in_ready`=1 one cycle after `rst` falls.
